// File: rtl/sysbus_mem_responder.sv
// Target end of the system bus: takes 64-byte line reads/writes against a word-addressed store.
// Reads come back as eight 64-bit beats, critical word first, after a fixed latency.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = AW - 3;
  localparam int CW = $clog2(LATENCY + 1);

  // state | meaning: IDLE wait request | ADDR_ACK ack address | WDATA take beats | WAIT latency | RESP send beats
  typedef enum logic [2:0] {IDLE, ADDR_ACK, WDATA, WAIT, RESP} state_t;

  state_t                     state_q, state_d;
  logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [BW-1:0]              base_q, base_d;
  logic [2:0]                 beat_q, beat_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [3:0]                 left_q, left_d;
  logic [31:0]                rd_count_d, wr_count_d;
  logic                       mem_we;
  logic                       is_mem;
  logic [AW-1:0]              idx;
  logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

  // Only the low address bits reach the store; upper address bits alias.
  assign idx    = {base_q, beat_q};
  assign is_mem = (tag_q[11:8] == 4'b0001);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      base_q   <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      rd_count <= rd_count_d;
      wr_count <= wr_count_d;
    end
  end

  // A beat presented on the same edge as reset is dropped, not stored.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx] <= bus_req;
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    base_d      = base_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    rd_count_d  = rd_count;
    wr_count_d  = wr_count;
    mem_we      = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    case (state_q)
      IDLE: begin
        if (bus_reqcyc) begin
          tag_d   = bus_reqtag;
          base_d  = bus_req[AW+2:6];
          beat_d  = bus_req[5:3];
          state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        bus_reqack = 1'b1;
        left_d     = 4'd8;
        if (tag_q[BUS_TAG_WIDTH-1]) begin
          cnt_d   = CW'(LATENCY);
          state_d = WAIT;
        end else begin
          state_d = WDATA;
        end
      end
      WDATA: begin
        bus_reqack = bus_reqcyc;
        if (bus_reqcyc) begin
          mem_we = is_mem;
          beat_d = beat_q + 3'd1;
          left_d = left_q - 4'd1;
          if (left_q == 4'd1) begin
            wr_count_d = wr_count + 32'd1;
            state_d    = IDLE;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: begin
        bus_respcyc = 1'b1;
        bus_resp    = is_mem ? mem[idx] : '0;
        bus_resptag = tag_q;
        if (bus_respack) begin
          beat_d = beat_q + 3'd1;
          left_d = left_q - 4'd1;
          if (left_q == 4'd1) begin
            rd_count_d = rd_count + 32'd1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: directed line reads/writes plus randomized aliased traffic,
// checked against an array model of the store indexed straight from the bus address.
module tb_sysbus_mem_responder;

  localparam int LAT   = 4;
  localparam int WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqcyc = 1'b0;
  logic        respack = 1'b0;
  logic [63:0] req = '0;
  logic [12:0] reqtag = '0;
  logic        reqack, respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic [31:0] rd_count, wr_count;

  int          tests = 0;
  int          failed = 0;
  logic [63:0] model_mem [WORDS];
  logic [31:0] rd_exp = '0;
  logic [31:0] wr_exp = '0;
  logic [63:0] beats [8];
  logic [63:0] pend_addr;
  logic [12:0] pend_tag;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_WORDS(WORDS), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(reqcyc), .bus_req(req), .bus_reqtag(reqtag), .bus_reqack(reqack),
    .bus_respcyc(respcyc), .bus_respack(respack), .bus_resp(resp), .bus_resptag(resptag),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Word k of a burst starting at addr: line base, critical word first, wrapped in the line.
  function automatic int widx(input logic [63:0] addr, input int k);
    logic [63:0] line_words;
    int          first;
    line_words = (addr >> 6) * 64'd8;
    first      = int'((addr >> 3) & 64'd7);
    return int'((line_words + 64'((first + k) % 8)) % 64'(WORDS));
  endfunction

  function automatic bit tag_is_mem(input logic [12:0] tag);
    return tag[11:8] == 4'b0001;
  endfunction

  task automatic wait_addr_ack(input logic [63:0] addr, input logic [12:0] tag);
    int n;
    @(negedge clk);
    reqcyc = 1'b1; req = addr; reqtag = tag;
    #1;
    n = 0;
    while (reqack !== 1'b1 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    check("addr_ack", 64'(reqack), 64'(1));
  endtask

  task automatic wr_burst(input logic [63:0] addr, input logic [12:0] tag,
                          input int stall_beat, input int stall_len, input int abort_beat);
    int i, st, acks, n;
    wait_addr_ack(addr, tag);
    @(negedge clk);
    i = 0; st = 0; acks = 0; n = 0;
    while (i < 8 && n < 100) begin
      if (i == abort_beat) begin
        reset = 1'b1; reqcyc = 1'b1; req = beats[i];
        @(negedge clk); #1;
        check("wr_abort_reqack", 64'(reqack), 64'(0));
        check("wr_abort_respcyc", 64'(respcyc), 64'(0));
        check("wr_abort_wr_count", 64'(wr_count), 64'(0));
        check("wr_abort_rd_count", 64'(rd_count), 64'(0));
        reset = 1'b0; reqcyc = 1'b0;
        rd_exp = '0; wr_exp = '0;
        return;
      end
      req    = beats[i];
      reqcyc = (i == stall_beat && st < stall_len) ? 1'b0 : 1'b1;
      #1;
      check("wr_beat_reqack", 64'(reqack), 64'(reqcyc));
      if (reqcyc) begin
        if (tag_is_mem(tag)) model_mem[widx(addr, i)] = beats[i];
        acks++; i++;
      end else begin
        st++;
      end
      @(negedge clk);
      n++;
    end
    reqcyc = 1'b0;
    #1;
    wr_exp++;
    check("wr_beat_acks", 64'(acks), 64'(8));
    check("wr_count", 64'(wr_count), 64'(wr_exp));
  endtask

  task automatic rd_burst(input logic [63:0] addr, input logic [12:0] tag,
                          input int hold_beat, input int hold_len,
                          input bit pend, input bit abort_wait);
    int c, i, h, n;
    bit pend_on;
    logic [63:0] exp;
    wait_addr_ack(addr, tag);
    reqcyc = 1'b0;
    if (abort_wait) begin
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      check("rd_abort_respcyc", 64'(respcyc), 64'(0));
      check("rd_abort_reqack", 64'(reqack), 64'(0));
      check("rd_abort_rd_count", 64'(rd_count), 64'(0));
      check("rd_abort_wr_count", 64'(wr_count), 64'(0));
      reset = 1'b0;
      rd_exp = '0; wr_exp = '0;
      for (int k = 0; k < LAT + 3; k++) begin
        @(negedge clk); #1;
        check("rd_abort_stays_idle", 64'(respcyc), 64'(0));
      end
      return;
    end
    c = 0;
    do begin
      @(negedge clk); #1; c++;
    end while (respcyc !== 1'b1 && c < 30);
    check("rd_first_beat_latency", 64'(c), 64'(LAT + 1));
    i = 0; h = 0; n = 0; pend_on = 1'b0;
    while (i < 8 && n < 100) begin
      exp = tag_is_mem(tag) ? model_mem[widx(addr, i)] : 64'h0;
      check("rd_respcyc", 64'(respcyc), 64'(1));
      check("rd_beat_data", resp, exp);
      check("rd_resptag", 64'(resptag), 64'(tag));
      if (pend && i >= 1) begin
        if (!pend_on) begin
          reqcyc = 1'b1; req = pend_addr; reqtag = pend_tag; pend_on = 1'b1;
          #1;
        end
        check("rd_pending_no_ack", 64'(reqack), 64'(0));
      end
      respack = (i == hold_beat && h < hold_len) ? 1'b0 : 1'b1;
      if (respack) i++; else h++;
      @(negedge clk); #1;
      n++;
    end
    respack = 1'b0;
    rd_exp++;
    check("rd_hold_cycles", 64'(h), 64'(hold_len));
    check("rd_end_respcyc", 64'(respcyc), 64'(0));
    check("rd_end_resp", resp, 64'h0);
    check("rd_end_resptag", 64'(resptag), 64'(0));
    check("rd_count", 64'(rd_count), 64'(rd_exp));
  endtask

  initial begin
    logic [63:0] a, b;
    int          sb, sl, hb, hl;

    repeat (3) @(negedge clk);
    #1;
    check("reset_reqack", 64'(reqack), 64'(0));
    check("reset_respcyc", 64'(respcyc), 64'(0));
    check("reset_resp", resp, 64'h0);
    check("reset_resptag", 64'(resptag), 64'(0));
    check("reset_rd_count", 64'(rd_count), 64'(0));
    check("reset_wr_count", 64'(wr_count), 64'(0));
    reset = 1'b0;

    for (int k = 0; k < 8; k++) beats[k] = 64'((k + 1) * 17);
    wr_burst(64'h40, 13'h0100, -1, 0, -1);
    rd_burst(64'h40, 13'h1100, -1, 0, 1'b0, 1'b0);
    rd_burst(64'h58, 13'h1105, -1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) beats[k] = 64'hA0 + 64'(k);
    wr_burst(64'h80, 13'h0100, 3, 2, -1);
    rd_burst(64'h80, 13'h1101, 2, 5, 1'b0, 1'b0);

    pend_addr = 64'h80; pend_tag = 13'h1103;
    rd_burst(64'h40, 13'h1102, -1, 0, 1'b1, 1'b0);
    rd_burst(64'h80, 13'h1103, -1, 0, 1'b0, 1'b0);

    rd_burst(64'h80, 13'h1300, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) beats[k] = 64'hDEAD_0000 + 64'(k);
    wr_burst(64'h80, 13'h0300, -1, 0, -1);
    rd_burst(64'h80, 13'h1104, -1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) beats[k] = 64'hB0 + 64'(k);
    wr_burst(64'h100, 13'h0101, -1, 0, -1);
    for (int k = 0; k < 8; k++) beats[k] = 64'hC0 + 64'(k);
    wr_burst(64'h100, 13'h0102, -1, 0, 4);
    rd_burst(64'h100, 13'h1106, -1, 0, 1'b0, 1'b0);

    rd_burst(64'h40, 13'h1107, -1, 0, 1'b0, 1'b1);
    rd_burst(64'h40, 13'h1108, -1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      a = {$urandom(), $urandom()};
      for (int k = 0; k < 8; k++) beats[k] = {$urandom(), $urandom()};
      sb = $urandom_range(0, 7); sl = $urandom_range(0, 3);
      wr_burst(a, {5'b00001, 8'(r)}, sb, sl, -1);
      b = a ^ ({$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_8000);
      b[5:3] = 3'($urandom_range(0, 7));
      b[2:0] = 3'($urandom_range(0, 7));
      hb = $urandom_range(0, 7); hl = $urandom_range(0, 3);
      rd_burst(b, {5'b10001, 8'(r)}, hb, hl, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
